// File: rtl/glb_stream_tx_pkg.sv
// rtl/glb_stream_tx_pkg.sv - shared NoC types: router direction codes and stream TX FSM states
package glb_stream_tx_pkg;

    // Router mode codes driven on router_mode_o.
    typedef enum logic [3:0] {
        ALL        = 4'd0,
        NORTH      = 4'd1,
        SOUTH      = 4'd2,
        WEST       = 4'd3,
        EAST       = 4'd4,
        NORTHSOUTH = 4'd5,
        NORTHWEST  = 4'd6,
        NORTHEAST  = 4'd7,
        SOUTHWEST  = 4'd8,
        SOUTHEAST  = 4'd9,
        WESTEAST   = 4'd10
    } router_dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - one-entry skid buffer between GLB read data and the router output register
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   s_tdata, s_tvalid word returning from the GLB this cycle
//   m_tready          output register may accept a word this cycle
//   m_tdata, m_tvalid oldest held word (buffered word first, else the arriving one)
module stream_skid_buf #(
    parameter int DATA_BITWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BITWIDTH-1:0] s_tdata,
    input  logic                     s_tvalid,
    input  logic                     m_tready,
    output logic [DATA_BITWIDTH-1:0] m_tdata,
    output logic                     m_tvalid
);

    logic                     full_q, full_d;
    logic [DATA_BITWIDTH-1:0] buf_q, buf_d;

    always_comb begin
        full_d   = full_q;
        buf_d    = buf_q;
        m_tvalid = full_q | s_tvalid;
        m_tdata  = full_q ? buf_q : s_tdata;
        // An arriving word is parked unless it passes straight through
        // (buffer empty and output ready). The issuer never lets a word
        // arrive while the buffer is full and the output is stalled.
        if (s_tvalid && (full_q || !m_tready)) begin
            buf_d  = s_tdata;
            full_d = 1'b1;
        end else if (full_q && m_tready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            buf_q  <= '0;
        end else begin
            full_q <= full_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/glb_stream_tx.sv
// rtl/glb_stream_tx.sv - streams a block of GLB words into the router west input
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   start_i, base_addr_i,
//   length_i, mode_i                transfer launch and its parameters (sampled in IDLE)
//   stall_i                         downstream hold; blocks reads and presentation
//   read_req_o, r_addr_o, r_data_i  GLB read port (data one cycle after request)
//   router_data_o, router_enable_o  registered word into the router, one per enable cycle
//   router_mode_o                   mode captured at the last accepted start
//   busy_o, done_o                  transfer in progress / one-cycle completion pulse
module glb_stream_tx
    import glb_stream_tx_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [ADDR_BITWIDTH-1:0] base_addr_i,
    input  logic [ADDR_BITWIDTH-1:0] length_i,
    input  logic [3:0]               mode_i,
    input  logic                     stall_i,
    output logic                     read_req_o,
    output logic [ADDR_BITWIDTH-1:0] r_addr_o,
    input  logic [DATA_BITWIDTH-1:0] r_data_i,
    output logic [DATA_BITWIDTH-1:0] router_data_o,
    output logic                     router_enable_o,
    output logic [3:0]               router_mode_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE = {{(ADDR_BITWIDTH-1){1'b0}}, 1'b1};

    tx_state_e                state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] base_q, base_d;
    logic [ADDR_BITWIDTH-1:0] len_q, len_d;
    logic [ADDR_BITWIDTH-1:0] issued_q, issued_d;
    logic [3:0]               mode_q, mode_d;
    logic                     pending_q, pending_d;
    logic [DATA_BITWIDTH-1:0] data_q, data_d;
    logic                     en_q, en_d;
    logic                     rd_req;
    logic [DATA_BITWIDTH-1:0] word_data;
    logic                     word_valid;

    // pending_q marks that r_data_i carries a word this cycle.
    stream_skid_buf #(
        .DATA_BITWIDTH(DATA_BITWIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  (r_data_i),
        .s_tvalid (pending_q),
        .m_tready (!stall_i),
        .m_tdata  (word_data),
        .m_tvalid (word_valid)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        mode_d   = mode_q;
        issued_d = issued_q;
        rd_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d   = base_addr_i;
                    len_d    = length_i;
                    mode_d   = mode_i;
                    issued_d = '0;
                    state_d  = (length_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Reads only go out while unstalled. With stall low the skid
                // slot is guaranteed empty by next cycle, so at most one word
                // is ever pending beyond the output register.
                if (!stall_i) begin
                    rd_req   = 1'b1;
                    issued_d = issued_q + ADDR_ONE;
                    if (issued_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Nothing arriving and nothing buffered: the last word is
                // either in the output register now or already gone.
                if (!word_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pending_d = rd_req;
        en_d      = word_valid && !stall_i;
        data_d    = en_d ? word_data : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            mode_q    <= ALL;
            pending_q <= 1'b0;
            data_q    <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            en_q      <= en_d;
        end
    end

    assign read_req_o      = rd_req;
    assign r_addr_o        = base_q + issued_q;
    assign router_data_o   = data_q;
    assign router_enable_o = en_q;
    assign router_mode_o   = mode_q;
    assign busy_o          = (state_q == RUN) || (state_q == DRAIN);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_glb_stream_tx.sv
// tb/tb_glb_stream_tx.sv - self-checking bench for glb_stream_tx
module tb_glb_stream_tx;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [9:0]  length_i;
    logic [3:0]  mode_i;
    logic        stall_i;
    logic        read_req_o;
    logic [9:0]  r_addr_o;
    logic [15:0] r_data_i;
    logic [15:0] router_data_o;
    logic        router_enable_o;
    logic [3:0]  router_mode_o;
    logic        busy_o;
    logic        done_o;

    glb_stream_tx #(
        .DATA_BITWIDTH(16),
        .ADDR_BITWIDTH(10)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .length_i        (length_i),
        .mode_i          (mode_i),
        .stall_i         (stall_i),
        .read_req_o      (read_req_o),
        .r_addr_o        (r_addr_o),
        .r_data_i        (r_data_i),
        .router_data_o   (router_data_o),
        .router_enable_o (router_enable_o),
        .router_mode_o   (router_mode_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GLB model: GLB[i] = 2*i, data one cycle after the request.
    logic [15:0] glb_mem [0:1023];
    always @(posedge clk) begin
        if (read_req_o) r_data_i <= glb_mem[r_addr_o];
    end

    typedef struct {
        logic       st;
        logic [9:0] base;
        logic [9:0] len;
        logic [3:0] mode;
        logic       stall;
        logic       req;
        logic [9:0] addr;
        logic       en;
        logic [15:0] data;
        logic       busy;
        logic       done;
        logic [3:0] omode;
    } vec_t;

    vec_t        vecs[$];
    logic [9:0]  cur_base;
    logic [9:0]  cur_len;
    logic [3:0]  cur_mode;
    int          n_checks;
    int          n_fail;
    logic [15:0] words[$];
    logic [9:0]  addrs[$];
    logic        done_seen;

    function automatic vec_t mk(input int st, input int s, input int rq, input int a,
                                input int en, input int d, input int bz, input int dn,
                                input int om);
        vec_t v;
        v.st    = st[0];
        v.base  = cur_base;
        v.len   = cur_len;
        v.mode  = cur_mode;
        v.stall = s[0];
        v.req   = rq[0];
        v.addr  = 10'(a);
        v.en    = en[0];
        v.data  = 16'(d);
        v.busy  = bz[0];
        v.done  = dn[0];
        v.omode = 4'(om);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then sample.
    task automatic cyc(input logic st, input int b, input int l, input int m, input logic s);
        @(negedge clk);
        start_i     = st;
        base_addr_i = 10'(b);
        length_i    = 10'(l);
        mode_i      = 4'(m);
        stall_i     = s;
        #1;
        if (router_enable_o) words.push_back(router_data_o);
        if (read_req_o) addrs.push_back(r_addr_o);
        if (done_o) done_seen = 1'b1;
    endtask

    task automatic clear_mon();
        words.delete();
        addrs.delete();
        done_seen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) glb_mem[i] = 16'(2 * i);
        reset = 1'b0;
        start_i = 1'b0; base_addr_i = '0; length_i = '0; mode_i = '0; stall_i = 1'b0;
        clear_mon();

        // Vector table (args: start, stall, req, addr, en, data, busy, done, mode).
        // base 0, len 4, EAST
        cur_base = 10'd0; cur_len = 10'd4; cur_mode = 4'd4;
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1,0,4));
        vecs.push_back(mk(0,0,1,1,0,0,1,0,4));
        vecs.push_back(mk(0,0,1,2,1,0,1,0,4));
        vecs.push_back(mk(0,0,1,3,1,2,1,0,4));
        vecs.push_back(mk(0,0,0,0,1,4,1,0,4));
        vecs.push_back(mk(0,0,0,0,1,6,1,0,4));
        vecs.push_back(mk(0,0,0,0,0,6,0,1,4));
        vecs.push_back(mk(0,0,0,0,0,6,0,0,4));
        // base 1022, len 4: address wrap
        cur_base = 10'd1022; cur_len = 10'd4; cur_mode = 4'd10;
        vecs.push_back(mk(1,0,0,0,0,6,0,0,4));
        vecs.push_back(mk(0,0,1,1022,0,6,1,0,10));
        vecs.push_back(mk(0,0,1,1023,0,6,1,0,10));
        vecs.push_back(mk(0,0,1,0,1,2044,1,0,10));
        vecs.push_back(mk(0,0,1,1,1,2046,1,0,10));
        vecs.push_back(mk(0,0,0,0,1,0,1,0,10));
        vecs.push_back(mk(0,0,0,0,1,2,1,0,10));
        vecs.push_back(mk(0,0,0,0,0,2,0,1,10));
        vecs.push_back(mk(0,0,0,0,0,2,0,0,10));
        // len 8, stall for 3 cycles after the 2nd read
        cur_base = 10'd0; cur_len = 10'd8; cur_mode = 4'd3;
        vecs.push_back(mk(1,0,0,0,0,2,0,0,10));
        vecs.push_back(mk(0,0,1,0,0,2,1,0,3));
        vecs.push_back(mk(0,0,1,1,0,2,1,0,3));
        vecs.push_back(mk(0,1,0,0,1,0,1,0,3));
        vecs.push_back(mk(0,1,0,0,0,0,1,0,3));
        vecs.push_back(mk(0,1,0,0,0,0,1,0,3));
        vecs.push_back(mk(0,0,1,2,0,0,1,0,3));
        vecs.push_back(mk(0,0,1,3,1,2,1,0,3));
        vecs.push_back(mk(0,0,1,4,1,4,1,0,3));
        vecs.push_back(mk(0,0,1,5,1,6,1,0,3));
        vecs.push_back(mk(0,0,1,6,1,8,1,0,3));
        vecs.push_back(mk(0,0,1,7,1,10,1,0,3));
        vecs.push_back(mk(0,0,0,0,1,12,1,0,3));
        vecs.push_back(mk(0,0,0,0,1,14,1,0,3));
        vecs.push_back(mk(0,0,0,0,0,14,0,1,3));
        vecs.push_back(mk(0,0,0,0,0,14,0,0,3));
        // len 0: done next cycle, no reads, never busy
        cur_base = 10'd50; cur_len = 10'd0; cur_mode = 4'd5;
        vecs.push_back(mk(1,0,0,0,0,14,0,0,3));
        vecs.push_back(mk(0,0,0,0,0,14,0,1,5));
        vecs.push_back(mk(0,0,0,0,0,14,0,0,5));
        // stall coinciding with the final read: read held back
        cur_base = 10'd10; cur_len = 10'd2; cur_mode = 4'd1;
        vecs.push_back(mk(1,0,0,0,0,14,0,0,5));
        vecs.push_back(mk(0,0,1,10,0,14,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,14,1,0,1));
        vecs.push_back(mk(0,0,1,11,0,14,1,0,1));
        vecs.push_back(mk(0,0,0,0,1,20,1,0,1));
        vecs.push_back(mk(0,0,0,0,1,22,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,22,0,1,1));
        vecs.push_back(mk(0,0,0,0,0,22,0,0,1));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              {read_req_o, r_addr_o, router_enable_o, router_data_o, busy_o, done_o, router_mode_o},
              34'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            logic [9:0] act_a;
            logic [9:0] exp_a;
            @(negedge clk);
            start_i     = vecs[i].st;
            base_addr_i = vecs[i].base;
            length_i    = vecs[i].len;
            mode_i      = vecs[i].mode;
            stall_i     = vecs[i].stall;
            #1;
            act_a = vecs[i].req ? r_addr_o : 10'd0;
            exp_a = vecs[i].req ? vecs[i].addr : 10'd0;
            check($sformatf("vec%0d", i),
                  {read_req_o, act_a, router_enable_o, router_data_o, busy_o, done_o, router_mode_o},
                  {vecs[i].req, exp_a, vecs[i].en, vecs[i].data, vecs[i].busy, vecs[i].done, vecs[i].omode});
        end

        // Start re-pulsed mid-transfer is ignored.
        clear_mon();
        cyc(1'b1, 0, 4, 4, 1'b0);
        for (int k = 0; k < 40 && !done_seen; k++) begin
            if (k == 1) cyc(1'b1, 100, 2, 9, 1'b0);
            else        cyc(1'b0, 0, 0, 0, 1'b0);
        end
        check("repulse_done", done_seen, 1);
        check("repulse_count", words.size(), 4);
        for (int i = 0; i < 4 && i < words.size(); i++)
            check($sformatf("repulse_word%0d", i), words[i], 2 * i);
        for (int i = 0; i < 4 && i < addrs.size(); i++)
            check($sformatf("repulse_addr%0d", i), addrs[i], i);
        check("repulse_mode", router_mode_o, 4);
        clear_mon();
        cyc(1'b0, 0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0);
        check("repulse_idle", {busy_o, addrs.size() != 0}, 2'b00);

        // Reset after the 3rd word of an 8-word transfer.
        clear_mon();
        cyc(1'b1, 0, 8, 2, 1'b0);
        for (int k = 0; k < 30 && words.size() < 3; k++) cyc(1'b0, 0, 0, 0, 1'b0);
        check("rst_three_words", words.size(), 3);
        check("rst_no_early_done", done_seen, 0);
        reset = 1'b0;
        #1;
        check("rst_outputs_zero",
              {read_req_o, r_addr_o, router_enable_o, router_data_o, busy_o, done_o, router_mode_o},
              34'd0);
        done_seen = 1'b0;
        cyc(1'b0, 0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0);
        check("rst_no_done", done_seen, 0);
        reset = 1'b1;
        cyc(1'b0, 0, 0, 0, 1'b0);
        check("rst_release_idle", {busy_o, done_o, read_req_o}, 3'b000);
        clear_mon();
        cyc(1'b1, 4, 2, 6, 1'b0);
        for (int k = 0; k < 20 && !done_seen; k++) cyc(1'b0, 0, 0, 0, 1'b0);
        check("rst_rerun_done", done_seen, 1);
        check("rst_rerun_count", words.size(), 2);
        if (words.size() == 2) begin
            check("rst_rerun_w0", words[0], 8);
            check("rst_rerun_w1", words[1], 10);
        end
        check("rst_rerun_mode", router_mode_o, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glb_stream_tx.md
GLB_STREAM_TX -- requirements
Module: glb_stream_tx

Interface
REQ-001 Parameter DATA_BITWIDTH, default 16, width of GLB words and router data.
REQ-002 Parameter ADDR_BITWIDTH, default 10, width of GLB addresses and transfer length.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
REQ-006 base_addr_i  in  ADDR_BITWIDTH  first GLB read address; captured on accepted start.
REQ-007 length_i  in  ADDR_BITWIDTH  number of words to send; captured on accepted start.
REQ-008 mode_i  in  4  router mode code (ALL=0 .. WESTEAST=10); captured on accepted start.
REQ-009 stall_i  in  1  downstream hold request; no word is presented in the cycle after stall_i is sampled high.
REQ-010 read_req_o  out  1  GLB read request.
REQ-011 r_addr_o  out  ADDR_BITWIDTH  GLB read address.
REQ-012 r_data_i  in  DATA_BITWIDTH  GLB read data, valid one cycle after read_req_o.
REQ-013 router_data_o  out  DATA_BITWIDTH  word driven into the router west data input.
REQ-014 router_enable_o  out  1  router west enable; exactly one word transfers per high cycle.
REQ-015 router_mode_o  out  4  held router mode for the duration of the transfer.
REQ-016 busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-017 done_o  out  1  one-cycle pulse after the last word is presented.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE: when start_i is high, go to RUN with length_i nonzero, or to DONE with length_i zero (no reads issued).
REQ-020 RUN: each cycle with stall_i low and a free skid slot, assert read_req_o with r_addr_o = base + issued count, mod 2^ADDR_BITWIDTH (wrap-around permitted).
REQ-021 RUN: after the length_i-th read is issued, go to DRAIN.
REQ-022 DRAIN: once all in-flight and buffered words are presented, go to DONE.
REQ-023 DONE: assert done_o for one cycle, then return to IDLE.
REQ-024 r_data_i returning while stall_i is high SHALL be captured in a one-entry skid buffer; no word is lost or duplicated.
REQ-025 router_data_o and router_enable_o SHALL be registered; unstalled latency from read_req_o to router_enable_o is 2 cycles.
REQ-026 Words SHALL be presented in strictly increasing address order, exactly length_i words per transfer.
REQ-027 No read SHALL be issued when the in-flight word plus the buffered word would exceed 1 pending word beyond the output register.
REQ-028 start_i while busy_o is high SHALL be ignored.
REQ-029 router_mode_o SHALL hold the captured mode from the accepted start until the next accepted start.
REQ-030 stall_i and the final read in the same cycle: the read is withheld until stall_i is low.
REQ-031 router_data_o SHALL hold its last value when router_enable_o is low.

Reset
REQ-032 On reset low, asynchronously: state IDLE; read_req_o, router_enable_o, busy_o, done_o = 0; r_addr_o, router_data_o = 0; router_mode_o = ALL (0); counters and skid buffer cleared.
REQ-033 Reset mid-transfer SHALL abandon the transfer with no done_o pulse; after release the block is in IDLE.

Structure
REQ-034 The router direction enum (ALL..WESTEAST) and the FSM state typedef SHALL live in the shared NoC package.
REQ-035 The skid buffer SHALL be one sub-module, stream_skid_buf, parameterised by DATA_BITWIDTH.

Verification
REQ-036 base=0, len=4, mode=EAST, no stall, GLB[i]=2i -> enable high 4 consecutive cycles with data 0,2,4,6; first enable 2 cycles after first read_req; router_mode_o=4; done_o 1 cycle after the last word.
REQ-037 base=1022, len=4 -> r_addr_o sequence 1022,1023,0,1; data order matches.
REQ-038 len=8, stall_i high for 3 cycles after the 2nd read -> exactly 8 words in order, none duplicated, enable low in the 3 stalled cycles.
REQ-039 len=0 -> no read_req_o, done_o pulses on the cycle after start, busy_o stays low.
REQ-040 start re-pulsed mid-transfer with base=100 -> ignored; the original sequence completes unchanged.
REQ-041 reset asserted after the 3rd word of len=8 -> all outputs 0 immediately, no done_o; a new start after release runs normally.
